// File: rtl/writeback_arbiter_if.sv
// Register-file write-port bus: pipeline result, MDU handshake, decode hazard query and
// the register-file write signals. The arbiter takes the slave view.
interface writeback_arbiter_if;
  logic        pipeValid;
  logic [4:0]  pipeRd;
  logic        pipeIsLoad;
  logic [2:0]  pipeLoadFunct3;
  logic [1:0]  pipeLoadAddrLow;
  logic [31:0] pipeResult;
  logic [31:0] loadWord;
  logic        stallPipe;
  logic        mduValid;
  logic [4:0]  mduRd;
  logic [31:0] mduResult;
  logic        mduReady;
  logic        mduIssue;
  logic [4:0]  mduIssueRd;
  logic [4:0]  hazardRs1;
  logic [4:0]  hazardRs2;
  logic [4:0]  hazardRd;
  logic        hazardStall;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;

  modport master (
    output pipeValid, pipeRd, pipeIsLoad, pipeLoadFunct3, pipeLoadAddrLow, pipeResult, loadWord,
    output mduValid, mduRd, mduResult, mduIssue, mduIssueRd,
    output hazardRs1, hazardRs2, hazardRd,
    input  stallPipe, mduReady, hazardStall, regWrite, writeRegister, writeData
  );

  modport slave (
    input  pipeValid, pipeRd, pipeIsLoad, pipeLoadFunct3, pipeLoadAddrLow, pipeResult, loadWord,
    input  mduValid, mduRd, mduResult, mduIssue, mduIssueRd,
    input  hazardRs1, hazardRs2, hazardRd,
    output stallPipe, mduReady, hazardStall, regWrite, writeRegister, writeData
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: in-order pipeline results merged with out-of-order MDU
// results through a one-entry buffer with starvation guard, plus an MDU destination scoreboard.
module writeback_arbiter #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  writeback_arbiter_if.slave  io_wb
);

  logic              r_buf_valid;
  logic [4:0]        r_buf_rd;
  logic [31:0]       r_buf_data;
  logic [3:0]        r_starve_cnt;
  logic [NUM_REGS-1:0] r_pending;

  logic              w_buf_valid_nxt;
  logic [4:0]        w_buf_rd_nxt;
  logic [31:0]       w_buf_data_nxt;
  logic [3:0]        w_starve_cnt_nxt;
  logic [31:0]       w_pend_ext;
  logic [31:0]       w_pend_nxt;

  logic              w_pipe_claim;
  logic              w_mdu_keep;
  logic              w_mdu_take;
  logic              w_force;
  logic              w_clr_en;
  logic [4:0]        w_clr_rd;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;
  logic [31:0]       w_ld_word;
  logic [31:0]       w_pipe_data;

  assign w_pipe_claim = io_wb.pipeValid && (io_wb.pipeRd != 5'd0) &&
                        (32'(io_wb.pipeRd) < NUM_REGS);
  assign w_mdu_keep   = (io_wb.mduRd != 5'd0) && (32'(io_wb.mduRd) < NUM_REGS);
  assign w_mdu_take   = io_wb.mduValid && !r_buf_valid;
  assign w_force      = r_buf_valid && (32'(r_starve_cnt) >= STARVE_LIMIT);

  // Pad the scoreboard to 32 bits so any 5-bit index is legal; bit 0 always reads clear.
  assign w_pend_ext   = 32'(r_pending) & ~32'd1;

  always_comb begin
    w_ld_byte = io_wb.loadWord[7:0];
    case (io_wb.pipeLoadAddrLow)
      2'd1:    w_ld_byte = io_wb.loadWord[15:8];
      2'd2:    w_ld_byte = io_wb.loadWord[23:16];
      2'd3:    w_ld_byte = io_wb.loadWord[31:24];
      default: w_ld_byte = io_wb.loadWord[7:0];
    endcase
    w_ld_half = io_wb.pipeLoadAddrLow[1] ? io_wb.loadWord[31:16] : io_wb.loadWord[15:0];
    case (io_wb.pipeLoadFunct3)
      3'b000:  w_ld_word = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_word = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_word = {24'd0, w_ld_byte};
      3'b101:  w_ld_word = {16'd0, w_ld_half};
      default: w_ld_word = io_wb.loadWord;
    endcase
    w_pipe_data = io_wb.pipeIsLoad ? w_ld_word : io_wb.pipeResult;
  end

  always_comb begin
    io_wb.regWrite      = 1'b0;
    io_wb.writeRegister = 5'd0;
    io_wb.writeData     = 32'd0;
    io_wb.stallPipe     = 1'b0;
    io_wb.mduReady      = 1'b0;
    io_wb.hazardStall   = 1'b0;
    w_buf_valid_nxt     = r_buf_valid;
    w_buf_rd_nxt        = r_buf_rd;
    w_buf_data_nxt      = r_buf_data;
    w_starve_cnt_nxt    = r_starve_cnt;
    w_clr_en            = 1'b0;
    w_clr_rd            = 5'd0;

    if (!reset) begin
      io_wb.mduReady    = !r_buf_valid;
      io_wb.stallPipe   = w_force && w_pipe_claim;
      io_wb.hazardStall = w_pend_ext[io_wb.hazardRs1] | w_pend_ext[io_wb.hazardRs2] |
                          w_pend_ext[io_wb.hazardRd];

      if (w_force) begin
        io_wb.regWrite      = 1'b1;
        io_wb.writeRegister = r_buf_rd;
        io_wb.writeData     = r_buf_data;
        w_buf_valid_nxt     = 1'b0;
        w_starve_cnt_nxt    = 4'd0;
        w_clr_en            = 1'b1;
        w_clr_rd            = r_buf_rd;
      end else if (w_pipe_claim) begin
        io_wb.regWrite      = 1'b1;
        io_wb.writeRegister = io_wb.pipeRd;
        io_wb.writeData     = w_pipe_data;
        if (w_mdu_take && w_mdu_keep) begin
          w_buf_valid_nxt = 1'b1;
          w_buf_rd_nxt    = io_wb.mduRd;
          w_buf_data_nxt  = io_wb.mduResult;
        end
        if (r_buf_valid && (r_starve_cnt != 4'hF)) begin
          w_starve_cnt_nxt = r_starve_cnt + 4'd1;
        end
      end else if (r_buf_valid) begin
        io_wb.regWrite      = 1'b1;
        io_wb.writeRegister = r_buf_rd;
        io_wb.writeData     = r_buf_data;
        w_buf_valid_nxt     = 1'b0;
        w_starve_cnt_nxt    = 4'd0;
        w_clr_en            = 1'b1;
        w_clr_rd            = r_buf_rd;
      end else if (w_mdu_take && w_mdu_keep) begin
        io_wb.regWrite      = 1'b1;
        io_wb.writeRegister = io_wb.mduRd;
        io_wb.writeData     = io_wb.mduResult;
        w_clr_en            = 1'b1;
        w_clr_rd            = io_wb.mduRd;
      end
    end
  end

  // Issue is applied after the writeback clear so a same-cycle set wins.
  always_comb begin
    w_pend_nxt = w_pend_ext;
    if (w_clr_en) begin
      w_pend_nxt[w_clr_rd] = 1'b0;
    end
    if (io_wb.mduIssue && (io_wb.mduIssueRd != 5'd0) && (32'(io_wb.mduIssueRd) < NUM_REGS)) begin
      w_pend_nxt[io_wb.mduIssueRd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid  <= 1'b0;
      r_buf_rd     <= 5'd0;
      r_buf_data   <= 32'd0;
      r_starve_cnt <= 4'd0;
      r_pending    <= '0;
    end else begin
      r_buf_valid  <= w_buf_valid_nxt;
      r_buf_rd     <= w_buf_rd_nxt;
      r_buf_data   <= w_buf_data_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_pending    <= w_pend_nxt[NUM_REGS-1:0];
    end
  end

endmodule
